// File: rtl/gpu_pkg.sv
// gpu_pkg
// Shared constants for the GPU slice: default framebuffer geometry, coordinate
// and address widths, the pixel colour type, and helpers that derive widths
// from the geometry. Used by gpu_framebuffer and its RAM.
package gpu_pkg;

  localparam int FB_WIDTH   = 400;
  localparam int FB_HEIGHT  = 240;
  localparam int FB_COLOR_W = 16;

  // Coordinates carry one spare bit so off-screen values are representable
  // and can be rejected rather than wrapping onto a visible pixel.
  function automatic int coordWidth(input int extent);
    return $clog2(extent) + 1;
  endfunction

  // Width of the per-buffer pixel index y*W + x.
  function automatic int pixWidth(input int w, input int h);
    return $clog2(w * h);
  endfunction

  localparam int FB_X_W    = coordWidth(FB_WIDTH);
  localparam int FB_Y_W    = coordWidth(FB_HEIGHT);
  localparam int FB_PIX_W  = pixWidth(FB_WIDTH, FB_HEIGHT);
  localparam int FB_ADDR_W = FB_PIX_W + 1;

  typedef logic [FB_COLOR_W-1:0] rgb555_t;

endpackage

// File: rtl/fb_dpram.sv
// fb_dpram
// Simple dual-port RAM: one write port and one registered read port, both on
// the rising edge of clk. Contents are never reset.
// Ports:
//   clk      - clock
//   i_we     - write enable
//   i_wAddr  - write address
//   i_wData  - write data
//   i_rEn    - read enable; o_rData updates on the next edge
//   i_rAddr  - read address
//   o_rData  - registered read data, holds when i_rEn is low
module fb_dpram
  import gpu_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_COLOR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wAddr,
  input  logic [DATA_W-1:0] i_wData,
  input  logic              i_rEn,
  input  logic [ADDR_W-1:0] i_rAddr,
  output logic [DATA_W-1:0] o_rData
);

  // Depth is the full power of two so the buffer index can sit at the
  // address MSB; the tail of each half above W*H is simply never touched.
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rData;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wAddr] <= i_wData;
    end
    if (i_rEn) begin
      r_rData <= r_mem[i_rAddr];
    end
  end

  assign o_rData = r_rData;

endmodule

// File: rtl/gpu_framebuffer.sv
// gpu_framebuffer
// Double-buffered framebuffer. The GPU draws into the back buffer while the
// display scans out the front buffer; a requested swap is executed on a
// vblank rising edge once the GPU is idle and no write is in flight.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   fb_x, fb_y, fb_color       - draw-write coordinate and colour
//   fb_write                   - draw-write strobe, one pixel per cycle
//   gpu_busy                   - GPU command in progress (blocks swaps)
//   swap_req                   - pulse requesting a front/back exchange
//   vblank                     - display vertical-blank level
//   scan_x, scan_y, scan_req   - scanout read coordinate and strobe
//   scan_color, scan_valid     - read result, two cycles after scan_req
//   swap_pending               - a swap is queued
//   swap_done                  - pulse when a swap executes
//   front_sel                  - index of the buffer being scanned out
module gpu_framebuffer #(
  parameter int  FB_WIDTH  = gpu_pkg::FB_WIDTH,
  parameter int  FB_HEIGHT = gpu_pkg::FB_HEIGHT,
  localparam int X_W       = gpu_pkg::coordWidth(FB_WIDTH),
  localparam int Y_W       = gpu_pkg::coordWidth(FB_HEIGHT)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] fb_x,
  input  logic [Y_W-1:0] fb_y,
  input  logic [15:0]    fb_color,
  input  logic           fb_write,
  input  logic           gpu_busy,
  input  logic           swap_req,
  input  logic           vblank,
  input  logic [X_W-1:0] scan_x,
  input  logic [Y_W-1:0] scan_y,
  input  logic           scan_req,
  output logic [15:0]    scan_color,
  output logic           scan_valid,
  output logic           swap_pending,
  output logic           swap_done,
  output logic           front_sel
);

  import gpu_pkg::*;

  localparam int PIX_W  = pixWidth(FB_WIDTH, FB_HEIGHT);
  localparam int ADDR_W = PIX_W + 1;

  logic              r_vblank;
  logic              w_vblankRise;
  logic              w_swapExec;
  logic              r_front;
  logic              r_pending;
  logic              r_done;

  logic              w_wrInRange;
  logic [PIX_W-1:0]  w_wrPix;
  logic              r_w1Valid;
  logic [ADDR_W-1:0] r_w1Addr;
  rgb555_t           r_w1Color;
  logic              w_ramWe;

  logic              w_rdInRange;
  logic [PIX_W-1:0]  w_rdPix;
  logic              r_r1Valid;
  logic              r_r1InRange;
  logic [ADDR_W-1:0] r_r1Addr;
  logic              r_r2Valid;
  logic              r_r2InRange;
  rgb555_t           w_ramQ;
  rgb555_t           w_scanColor;
  rgb555_t           r_heldColor;

  assign w_wrInRange = (fb_x < X_W'(FB_WIDTH)) && (fb_y < Y_W'(FB_HEIGHT));
  assign w_rdInRange = (scan_x < X_W'(FB_WIDTH)) && (scan_y < Y_W'(FB_HEIGHT));
  assign w_wrPix     = PIX_W'(fb_y) * PIX_W'(FB_WIDTH) + PIX_W'(fb_x);
  assign w_rdPix     = PIX_W'(scan_y) * PIX_W'(FB_WIDTH) + PIX_W'(scan_x);

  // Write stage W1: off-screen writes are dropped here so they can never
  // alias onto a visible pixel. The target buffer is latched now, so a swap
  // after capture does not redirect the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w1Valid <= 1'b0;
    end else begin
      r_w1Valid <= fb_write && w_wrInRange;
    end
  end

  always_ff @(posedge clk) begin
    r_w1Addr  <= {~r_front, w_wrPix};
    r_w1Color <= fb_color;
  end

  // Gating with reset discards a write caught in W1 when reset arrives.
  assign w_ramWe = r_w1Valid && !reset;

  // Read stages: R1 latches address and buffer, R2 is the RAM read cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r1Valid <= 1'b0;
      r_r2Valid <= 1'b0;
    end else begin
      r_r1Valid <= scan_req;
      r_r2Valid <= r_r1Valid;
    end
  end

  always_ff @(posedge clk) begin
    r_r1InRange <= w_rdInRange;
    r_r1Addr    <= {r_front, w_rdPix};
    r_r2InRange <= r_r1InRange;
  end

  fb_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_wAddr (r_w1Addr),
    .i_wData (r_w1Color),
    .i_rEn   (r_r1Valid),
    .i_rAddr (r_r1Addr),
    .o_rData (w_ramQ)
  );

  // Out-of-range reads return black; between reads the last colour is held.
  always_comb begin
    w_scanColor = r_heldColor;
    if (r_r2Valid) begin
      w_scanColor = r_r2InRange ? w_ramQ : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_heldColor <= '0;
    end else begin
      r_heldColor <= w_scanColor;
    end
  end

  // Swap control. A swap_req landing on the executing edge re-arms pending.
  assign w_vblankRise = vblank && !r_vblank;
  assign w_swapExec   = w_vblankRise && r_pending && !gpu_busy && !r_w1Valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vblank  <= 1'b0;
      r_front   <= 1'b0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_vblank <= vblank;
      r_done   <= w_swapExec;
      if (w_swapExec) begin
        r_front   <= ~r_front;
        r_pending <= swap_req;
      end else if (swap_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign scan_color   = w_scanColor;
  assign scan_valid   = r_r2Valid;
  assign swap_pending = r_pending;
  assign swap_done    = r_done;
  assign front_sel    = r_front;

endmodule

// File: tb/tb_gpu_framebuffer.sv
// tb_gpu_framebuffer
// Self-checking bench for gpu_framebuffer. A reference model keeps both
// buffers as an associative array indexed by (buffer, x, y) plus the
// expected front buffer index; scenario tasks drive the DUT and compare.
module tb_gpu_framebuffer;

  localparam int W   = 400;
  localparam int H   = 240;
  localparam int X_W = $clog2(W) + 1;
  localparam int Y_W = $clog2(H) + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [X_W-1:0] fb_x = '0;
  logic [Y_W-1:0] fb_y = '0;
  logic [15:0]    fb_color = '0;
  logic           fb_write = 1'b0;
  logic           gpu_busy = 1'b0;
  logic           swap_req = 1'b0;
  logic           vblank = 1'b0;
  logic [X_W-1:0] scan_x = '0;
  logic [Y_W-1:0] scan_y = '0;
  logic           scan_req = 1'b0;
  logic [15:0]    scan_color;
  logic           scan_valid;
  logic           swap_pending;
  logic           swap_done;
  logic           front_sel;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [15:0] mMem [int];
  logic        mFront = 1'b0;

  gpu_framebuffer #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fb_x         (fb_x),
    .fb_y         (fb_y),
    .fb_color     (fb_color),
    .fb_write     (fb_write),
    .gpu_busy     (gpu_busy),
    .swap_req     (swap_req),
    .vblank       (vblank),
    .scan_x       (scan_x),
    .scan_y       (scan_y),
    .scan_req     (scan_req),
    .scan_color   (scan_color),
    .scan_valid   (scan_valid),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_sel    (front_sel)
  );

  always #5 clk = ~clk;

  function automatic int key(input logic b, input int x, input int y);
    return (b ? W * H : 0) + y * W + x;
  endfunction

  function automatic logic [15:0] expRead(input int x, input int y);
    if (x >= W || y >= H) return 16'h0000;
    return mMem[key(mFront, x, y)];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writePix(input int x, input int y, input logic [15:0] c);
    fb_x = X_W'(x);
    fb_y = Y_W'(y);
    fb_color = c;
    fb_write = 1'b1;
    step();
    fb_write = 1'b0;
    if (x < W && y < H) mMem[key(!mFront, x, y)] = c;
  endtask

  task automatic readPix(input int x, input int y, output logic v, output logic [15:0] c);
    scan_x = X_W'(x);
    scan_y = Y_W'(y);
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    step();
    v = scan_valid;
    c = scan_color;
  endtask

  task automatic requestSwap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  // Request a swap, give it a clean vblank edge and confirm it executed.
  task automatic doSwap();
    requestSwap();
    step();
    vblank = 1'b1;
    step();
    nVectors++;
    if (front_sel !== !mFront || swap_done !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL doSwap: front_sel=%b swap_done=%b, expected front_sel=%b swap_done=1",
               front_sel, swap_done, !mFront);
    end
    mFront = !mFront;
    vblank = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    nVectors++;
    if (front_sel !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_front_sel: got %b expected 0", front_sel); end
    nVectors++;
    if (swap_pending !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_swap_pending: got %b expected 0", swap_pending); end
    nVectors++;
    if (swap_done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_swap_done: got %b expected 0", swap_done); end
    nVectors++;
    if (scan_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_scan_valid: got %b expected 0", scan_valid); end
    nVectors++;
    if (scan_color !== 16'h0000) begin nMiscompares++; $display("[TB] FAIL reset_scan_color: got %h expected 0000", scan_color); end
    reset = 1'b0;
    mFront = 1'b0;
    step();
  endtask

  task automatic test_basic();
    writePix(5, 7, 16'h1235);
    requestSwap();
    nVectors++;
    if (swap_pending !== 1'b1) begin nMiscompares++; $display("[TB] FAIL basic_pending: got %b expected 1", swap_pending); end
    vblank = 1'b1;
    step();
    nVectors++;
    if (front_sel !== 1'b1 || swap_done !== 1'b1 || swap_pending !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL basic_swap: front_sel=%b swap_done=%b swap_pending=%b, expected 1 1 0",
               front_sel, swap_done, swap_pending);
    end
    mFront = 1'b1;
    vblank = 1'b0;
    step();
    nVectors++;
    if (swap_done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_done_width: got %b expected 0", swap_done); end
    scan_x = X_W'(5);
    scan_y = Y_W'(7);
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    nVectors++;
    if (scan_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_early_valid: got %b expected 0", scan_valid); end
    step();
    nVectors++;
    if (scan_valid !== 1'b1 || scan_color !== expRead(5, 7)) begin
      nMiscompares++;
      $display("[TB] FAIL basic_read: valid=%b color=%h, expected valid=1 color=%h", scan_valid, scan_color, expRead(5, 7));
    end
    step();
    nVectors++;
    if (scan_valid !== 1'b0 || scan_color !== 16'h1235) begin
      nMiscompares++;
      $display("[TB] FAIL basic_hold: valid=%b color=%h, expected valid=0 color=1235", scan_valid, scan_color);
    end
  endtask

  task automatic test_out_of_range();
    logic        v;
    logic [15:0] c;
    for (int pass = 0; pass < 2; pass++) begin
      writePix(0, 11, 16'h0A0A + 16'(pass));
      writePix(3, 0, 16'h0303 + 16'(pass));
      writePix(400, 10, 16'hFFFF);
      writePix(3, 240, 16'hFFFF);
      doSwap();
      readPix(0, 11, v, c);
      nVectors++;
      if (v !== 1'b1 || c !== expRead(0, 11)) begin
        nMiscompares++;
        $display("[TB] FAIL oor_keep_0_11: valid=%b color=%h, expected 1 %h", v, c, expRead(0, 11));
      end
      readPix(3, 0, v, c);
      nVectors++;
      if (v !== 1'b1 || c !== expRead(3, 0)) begin
        nMiscompares++;
        $display("[TB] FAIL oor_keep_3_0: valid=%b color=%h, expected 1 %h", v, c, expRead(3, 0));
      end
    end
    readPix(400, 0, v, c);
    nVectors++;
    if (v !== 1'b1 || c !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL oor_scan: valid=%b color=%h, expected 1 0000", v, c);
    end
  endtask

  task automatic test_busy_defer();
    requestSwap();
    gpu_busy = 1'b1;
    vblank = 1'b1;
    step();
    nVectors++;
    if (front_sel !== mFront || swap_pending !== 1'b1 || swap_done !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL busy_defer: front_sel=%b pending=%b done=%b, expected %b 1 0",
               front_sel, swap_pending, swap_done, mFront);
    end
    vblank = 1'b0;
    step();
    gpu_busy = 1'b0;
    vblank = 1'b1;
    step();
    nVectors++;
    if (front_sel !== !mFront || swap_pending !== 1'b0 || swap_done !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL busy_release: front_sel=%b pending=%b done=%b, expected %b 0 1",
               front_sel, swap_pending, swap_done, !mFront);
    end
    mFront = !mFront;
    vblank = 1'b0;
    step();
    nVectors++;
    if (swap_done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL busy_done_width: got %b expected 0", swap_done); end
  endtask

  task automatic test_write_defer();
    logic        v;
    logic [15:0] c;
    requestSwap();
    fb_x = X_W'(10);
    fb_y = Y_W'(20);
    fb_color = 16'h5A5B;
    fb_write = 1'b1;
    step();
    mMem[key(!mFront, 10, 20)] = 16'h5A5B;
    fb_x = X_W'(11);
    fb_color = 16'h5A5C;
    vblank = 1'b1;
    step();
    mMem[key(!mFront, 11, 20)] = 16'h5A5C;
    fb_write = 1'b0;
    nVectors++;
    if (front_sel !== mFront || swap_pending !== 1'b1 || swap_done !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL wdefer_hold: front_sel=%b pending=%b done=%b, expected %b 1 0",
               front_sel, swap_pending, swap_done, mFront);
    end
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    step();
    nVectors++;
    if (front_sel !== !mFront || swap_done !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL wdefer_exec: front_sel=%b done=%b, expected %b 1", front_sel, swap_done, !mFront);
    end
    mFront = !mFront;
    vblank = 1'b0;
    step();
    readPix(10, 20, v, c);
    nVectors++;
    if (v !== 1'b1 || c !== expRead(10, 20)) begin
      nMiscompares++;
      $display("[TB] FAIL wdefer_pix_a: valid=%b color=%h, expected 1 %h", v, c, expRead(10, 20));
    end
    readPix(11, 20, v, c);
    nVectors++;
    if (v !== 1'b1 || c !== expRead(11, 20)) begin
      nMiscompares++;
      $display("[TB] FAIL wdefer_pix_b: valid=%b color=%h, expected 1 %h", v, c, expRead(11, 20));
    end
  endtask

  task automatic test_swap_coincident();
    requestSwap();
    swap_req = 1'b1;
    vblank = 1'b1;
    step();
    swap_req = 1'b0;
    nVectors++;
    if (front_sel !== !mFront || swap_pending !== 1'b1 || swap_done !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL coinc_exec: front_sel=%b pending=%b done=%b, expected %b 1 1",
               front_sel, swap_pending, swap_done, !mFront);
    end
    mFront = !mFront;
    vblank = 1'b0;
    step();
    nVectors++;
    if (swap_pending !== 1'b1) begin nMiscompares++; $display("[TB] FAIL coinc_requeued: got %b expected 1", swap_pending); end
    vblank = 1'b1;
    step();
    nVectors++;
    if (front_sel !== !mFront || swap_pending !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL coinc_second: front_sel=%b pending=%b, expected %b 0", front_sel, swap_pending, !mFront);
    end
    mFront = !mFront;
    vblank = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic        v;
    logic [15:0] c;
    if (mFront == 1'b0) doSwap();
    writePix(7, 7, 16'h7777);
    step();
    requestSwap();
    fb_x = X_W'(7);
    fb_y = Y_W'(7);
    fb_color = 16'hBAD0;
    fb_write = 1'b1;
    scan_x = X_W'(5);
    scan_y = Y_W'(7);
    scan_req = 1'b1;
    step();
    fb_write = 1'b0;
    scan_req = 1'b0;
    reset = 1'b1;
    step();
    nVectors++;
    if (scan_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rstmid_valid_a: got %b expected 0", scan_valid); end
    reset = 1'b0;
    step();
    nVectors++;
    if (scan_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rstmid_valid_b: got %b expected 0", scan_valid); end
    nVectors++;
    if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL rstmid_state: front_sel=%b pending=%b, expected 0 0", front_sel, swap_pending);
    end
    mFront = 1'b0;
    readPix(7, 7, v, c);
    nVectors++;
    if (v !== 1'b1 || c !== expRead(7, 7)) begin
      nMiscompares++;
      $display("[TB] FAIL rstmid_write_dropped: valid=%b color=%h, expected 1 %h", v, c, expRead(7, 7));
    end
  endtask

  // Random draws into the back buffer, swap, then concurrent random reads of
  // the front and draws into the new back, then swap and read those back.
  task automatic test_random();
    int          xs [$];
    int          ys [$];
    int          xs2 [$];
    int          ys2 [$];
    logic [15:0] expQ [$];
    logic [15:0] e;
    logic        v;
    logic [15:0] c;
    int          x;
    int          y;
    int          k;
    for (int i = 0; i < 120; i++) begin
      x = int'($urandom_range(0, W + 9));
      y = int'($urandom_range(0, H + 5));
      writePix(x, y, 16'($urandom()));
      if (x < W && y < H) begin xs.push_back(x); ys.push_back(y); end
    end
    doSwap();
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) begin
        x = int'($urandom_range(0, W + 9));
        y = int'($urandom_range(0, H + 5));
        fb_x = X_W'(x);
        fb_y = Y_W'(y);
        fb_color = 16'($urandom());
        fb_write = 1'b1;
        if (x < W && y < H) begin
          mMem[key(!mFront, x, y)] = fb_color;
          xs2.push_back(x);
          ys2.push_back(y);
        end
        if ($urandom_range(0, 7) == 0 || xs.size() == 0) begin
          x = W + int'($urandom_range(0, 50));
          y = int'($urandom_range(0, H - 1));
        end else begin
          k = int'($urandom_range(0, xs.size() - 1));
          x = xs[k];
          y = ys[k];
        end
        scan_x = X_W'(x);
        scan_y = Y_W'(y);
        scan_req = 1'b1;
        expQ.push_back(expRead(x, y));
      end else begin
        fb_write = 1'b0;
        scan_req = 1'b0;
      end
      step();
      if (i >= 1) begin
        e = expQ.pop_front();
        nVectors++;
        if (scan_valid !== 1'b1 || scan_color !== e) begin
          nMiscompares++;
          $display("[TB] FAIL rand_read[%0d]: valid=%b color=%h, expected 1 %h", i - 1, scan_valid, scan_color, e);
        end
      end
    end
    fb_write = 1'b0;
    doSwap();
    for (int i = 0; i < 20 && xs2.size() > 0; i++) begin
      k = int'($urandom_range(0, xs2.size() - 1));
      readPix(xs2[k], ys2[k], v, c);
      nVectors++;
      if (v !== 1'b1 || c !== expRead(xs2[k], ys2[k])) begin
        nMiscompares++;
        $display("[TB] FAIL rand_concurrent_write[%0d]: valid=%b color=%h, expected 1 %h",
                 i, v, c, expRead(xs2[k], ys2[k]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_range();
    test_busy_defer();
    test_write_defer();
    test_swap_coincident();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/gpu_framebuffer.md
GPU_FRAMEBUFFER -- requirements
Module: gpu_framebuffer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 400, visible pixels per line.
REQ-002 SHALL have parameter FB_HEIGHT, default 240, visible lines per frame.
REQ-003 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port fb_x, input, $clog2(FB_WIDTH)+1, draw-write x coordinate from the GPU.
REQ-006 SHALL have port fb_y, input, $clog2(FB_HEIGHT)+1, draw-write y coordinate.
REQ-007 SHALL have port fb_color, input, 16, RGB555 colour with bit0 as the transparency flag (ignored here).
REQ-008 SHALL have port fb_write, input, 1, write strobe, one pixel per cycle.
REQ-009 SHALL have port gpu_busy, input, 1, GPU command in progress.
REQ-010 SHALL have port swap_req, input, 1, one-cycle pulse requesting a front/back exchange.
REQ-011 SHALL have port vblank, input, 1, display vertical-blank level.
REQ-012 SHALL have port scan_x, input, $clog2(FB_WIDTH)+1, scanout read x coordinate.
REQ-013 SHALL have port scan_y, input, $clog2(FB_HEIGHT)+1, scanout read y coordinate.
REQ-014 SHALL have port scan_req, input, 1, scanout read strobe.
REQ-015 SHALL have port scan_color, output, 16, read pixel.
REQ-016 SHALL have port scan_valid, output, 1, scan_color is valid this cycle.
REQ-017 SHALL have port swap_pending, output, 1, a swap is queued.
REQ-018 SHALL have port swap_done, output, 1, one-cycle pulse when a swap executes.
REQ-019 SHALL have port front_sel, output, 1, index of the buffer currently scanned out.

Function
REQ-020 SHALL hold two buffers of FB_WIDTH*FB_HEIGHT 16-bit words; pixel address = y*FB_WIDTH + x, 17 bits at default size, with the buffer index as the MSB.
REQ-021 SHALL register each write (address, colour, buffer = !front_sel) in stage W1 and commit it to memory on the following edge: 2-cycle write latency.
REQ-022 SHALL drop writes with fb_x >= FB_WIDTH or fb_y >= FB_HEIGHT at W1 capture, leaving memory unchanged.
REQ-023 SHALL write all 16 bits of fb_color, bit0 included, with no transparency filtering.
REQ-024 SHALL register each scan request (address, buffer = front_sel) in stage R1, read memory in R2, and present scan_color with scan_valid=1 exactly 2 cycles after scan_req.
REQ-025 SHALL return scan_color=0 with scan_valid=1 for an out-of-range scan request.
REQ-026 SHALL drive scan_valid=0 and hold the last scan_color when no request is completing.
REQ-027 SHALL set swap_pending on swap_req; a swap_req while already pending SHALL have no effect.
REQ-028 SHALL detect the vblank rising edge as registered vblank=0 with current vblank=1.
REQ-029 SHALL execute a swap on a vblank rising edge only when swap_pending=1, gpu_busy=0, and W1 is empty; executing SHALL toggle front_sel, clear swap_pending, and pulse swap_done for 1 cycle.
REQ-030 SHALL defer the swap to a later vblank rising edge if any REQ-029 condition fails, keeping swap_pending=1.
REQ-031 SHALL keep swap_pending=1 after the swap when swap_req coincides with an executing swap, queuing a new request.
REQ-032 SHALL complete any in-flight write or read against the buffer latched at capture, regardless of a swap.
REQ-033 SHALL service a write and a read in the same cycle with no stall.

Reset
REQ-034 SHALL on reset set front_sel=0, swap_pending=0, swap_done=0, scan_valid=0, scan_color=0, clear W1/R1/R2 valid flags, and clear the registered vblank.
REQ-035 SHALL discard in-flight writes and reads on reset mid-operation, neither committing nor returning them.
REQ-036 SHALL NOT reset memory contents.

Structure
REQ-037 SHALL place FB_WIDTH, FB_HEIGHT, coordinate widths, and address width in the shared package gpu_pkg, also used by gpu.
REQ-038 SHALL instantiate one sub-module, fb_dpram: a simple dual-port RAM, 1 write port and 1 registered read port, depth 2*FB_WIDTH*FB_HEIGHT, width 16.

Verification
REQ-039 SHALL verify: write (5,7)=0x1235 with front_sel=0, swap at vblank, then scan (5,7) -> scan_color=0x1235, scan_valid=1 two cycles after scan_req.
REQ-040 SHALL verify: write (400,10)=0xFFFF and (3,240)=0xFFFF -> both buffers unchanged at (0,11) and (3,0); out-of-range scan (400,0) -> scan_color=0.
REQ-041 SHALL verify: swap_req with gpu_busy=1 across the first vblank edge -> no swap and swap_pending=1; gpu_busy=0 at the next edge -> front_sel toggles and swap_done pulses 1 cycle.
REQ-042 SHALL verify: fb_write on the vblank-edge cycle with swap pending -> swap deferred one edge; the pixel lands in the old back buffer.
REQ-043 SHALL verify: swap_req coincident with an executing swap -> front_sel toggles and swap_pending remains 1.
REQ-044 SHALL verify: reset asserted 1 cycle after scan_req -> no scan_valid pulse; front_sel=0 and swap_pending=0 after reset.
